pc_gen_stage: RTL

PC_GEN_STAGE -- requirements
Module: pc_gen_stage

---
 rtl/pc_gen_stage_pkg.sv | 27 ++
 rtl/pc_gen_stage.sv | 94 +++++++++
 2 files changed

// File: rtl/pc_gen_stage_pkg.sv
// Shared common header for the fetch front end.
// Holds the reset vector, both exception vectors, the PC generator FSM state
// encoding and the exception codes.
package pc_gen_stage_pkg;

  // Boot ROM entry.
  localparam logic [31:0] ResetVector   = 32'hBFC00000;
  // General exception vector with BEV=1 (boot) and BEV=0 (normal).
  localparam logic [31:0] ExcVectorBev  = 32'hBFC00380;
  localparam logic [31:0] ExcVectorNorm = 32'h80000180;

  // PC generator states: sequential fetch, or branch waiting for its delay slot.
  typedef enum logic [0:0] {
    StSeq    = 1'b0,
    StDsWait = 1'b1
  } pc_state_e;

  // Cause register exception codes.
  localparam logic [4:0] ExcCodeInt  = 5'd0;
  localparam logic [4:0] ExcCodeAdel = 5'd4;
  localparam logic [4:0] ExcCodeAdes = 5'd5;
  localparam logic [4:0] ExcCodeSys  = 5'd8;
  localparam logic [4:0] ExcCodeBp   = 5'd9;
  localparam logic [4:0] ExcCodeRi   = 5'd10;
  localparam logic [4:0] ExcCodeOv   = 5'd12;

endpackage

// File: rtl/pc_gen_stage.sv
// Fetch PC generator: sequential PC, branch redirect with delay-slot tracking,
// exception and ERET flushes.
// Build option: define PC_GEN_BEV_EN to use the BEV exception vector
// (0xBFC00380); otherwise the normal vector (0x80000180) is used.
module pc_gen_stage
  import pc_gen_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic        valid_o,
  output logic [31:0] pc_o,
  input  logic        ready_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic        redirect_o
);

`ifdef PC_GEN_BEV_EN
  localparam logic [31:0] ExcVector = ExcVectorBev;
`else
  localparam logic [31:0] ExcVector = ExcVectorNorm;
`endif

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q;

  logic fire;
  logic ds_hit;
  logic br_accept;

  assign fire      = valid_q & ready_i;
  // The delay slot is the word right after the branch; if it is the one being
  // offered now, the branch target must wait until that slot is accepted.
  assign ds_hit    = (pc_q == (br_pc_i + 32'd4));
  // Decode never resolves a branch sitting in a delay slot, so ignore it here.
  assign br_accept = br_taken_i & (state_q == StSeq);

  assign redirect_o = exc_i | eret_i | br_accept;
  assign valid_o    = valid_q;
  assign pc_o       = pc_q;

  // Next-PC selection in priority order: exception, ERET, branch, pending, sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (exc_i) begin
      pc_d    = ExcVector;
      state_d = StSeq;
      tgt_d   = '0;
    end else if (eret_i) begin
      pc_d    = epc_i;
      state_d = StSeq;
      tgt_d   = '0;
    end else if (br_accept) begin
      if (ds_hit && !fire) begin
        tgt_d   = br_target_i;
        state_d = StDsWait;
      end else begin
        pc_d = br_target_i;
      end
    end else if (state_q == StDsWait) begin
      if (fire) begin
        pc_d    = tgt_q;
        state_d = StSeq;
        tgt_d   = '0;
      end
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // State, PC and pending-target registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StSeq;
      pc_q    <= ResetVector;
      tgt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      valid_q <= 1'b1;
    end
  end

endmodule
